// File: rtl/contactor_pkg.sv
// Shared types for the contactor sequencer: FSM states and latched fault codes.
package contactor_pkg;

  typedef enum logic [2:0] {
    OPEN,
    CLOSING,
    CLOSED,
    OPENING,
    FAULT
  } state_e;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_CLOSE_TO = 2'b01;
  localparam logic [1:0] FLT_DROP     = 2'b10;
  localparam logic [1:0] FLT_WELD     = 2'b11;

endpackage

// File: rtl/contactor_ctrl_fb_debounce.sv
// Two-flop synchroniser plus stability counter for one raw contact input.
// The output flips only after DEBOUNCE_CYC consecutive disagreeing samples.
module fb_debounce #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int CNT_W        = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_db
);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_db;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b00;
      r_cnt  <= '0;
      r_db   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        r_db  <= r_sync[1];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/contactor_ctrl.sv
// Contactor sequencer: drives the coil from permit/request, supervises close and
// open timing against debounced aux feedback, and latches the first fault seen.
module contactor_ctrl
  import contactor_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = 16,
  parameter int CLOSE_TIMEOUT = 1000,
  parameter int OPEN_TIMEOUT  = 1000,
  parameter int CNT_W         = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_close,
  input  logic       i_permit,
  input  logic       i_aux_fb,
  input  logic       i_fault_clr,
  output logic       o_coil,
  output logic       o_fb_db,
  output logic       o_closed,
  output logic       o_busy,
  output logic       o_fault,
  output logic [1:0] o_fault_code
);

  state_e           r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_coil, r_closed, r_busy, r_fault;
  logic [1:0]       r_code;
  logic             w_fb_db;
  logic             w_drop;

  fb_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .CNT_W        (CNT_W)
  ) u_fb_db (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_raw   (i_aux_fb),
    .o_db    (w_fb_db)
  );

  // Losing permit or request always wins over feedback, which wins over timeout.
  assign w_drop = ~i_permit | ~i_req_close;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= OPEN;
      r_timer  <= '0;
      r_coil   <= 1'b0;
      r_closed <= 1'b0;
      r_busy   <= 1'b0;
      r_fault  <= 1'b0;
      r_code   <= FLT_NONE;
    end else begin
      case (r_state)
        OPEN: begin
          r_timer <= '0;
          if (w_fb_db) begin
            r_state <= FAULT;
            r_fault <= 1'b1;
            r_code  <= FLT_WELD;
          end else if (i_req_close & i_permit) begin
            r_state <= CLOSING;
            r_coil  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        CLOSING: begin
          if (w_drop) begin
            r_state <= OPENING;
            r_coil  <= 1'b0;
            r_timer <= '0;
          end else if (w_fb_db) begin
            r_state  <= CLOSED;
            r_closed <= 1'b1;
            r_busy   <= 1'b0;
          end else if (r_timer == CNT_W'(CLOSE_TIMEOUT - 1)) begin
            r_state <= FAULT;
            r_coil  <= 1'b0;
            r_busy  <= 1'b0;
            r_fault <= 1'b1;
            r_code  <= FLT_CLOSE_TO;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        CLOSED: begin
          if (w_drop) begin
            r_state  <= OPENING;
            r_coil   <= 1'b0;
            r_closed <= 1'b0;
            r_busy   <= 1'b1;
            r_timer  <= '0;
          end else if (!w_fb_db) begin
            r_state  <= FAULT;
            r_coil   <= 1'b0;
            r_closed <= 1'b0;
            r_fault  <= 1'b1;
            r_code   <= FLT_DROP;
          end
        end
        OPENING: begin
          if (!w_fb_db) begin
            r_state <= OPEN;
            r_busy  <= 1'b0;
          end else if (r_timer == CNT_W'(OPEN_TIMEOUT - 1)) begin
            r_state <= FAULT;
            r_busy  <= 1'b0;
            r_fault <= 1'b1;
            r_code  <= FLT_WELD;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        FAULT: begin
          r_timer <= '0;
          // Request must be released and the contact seen open before re-arming.
          if (i_fault_clr & ~i_req_close & ~w_fb_db) begin
            r_state <= OPEN;
            r_fault <= 1'b0;
            r_code  <= FLT_NONE;
          end
        end
        default: begin
          r_state  <= OPEN;
          r_timer  <= '0;
          r_coil   <= 1'b0;
          r_closed <= 1'b0;
          r_busy   <= 1'b0;
          r_fault  <= 1'b0;
          r_code   <= FLT_NONE;
        end
      endcase
    end
  end

  assign o_coil       = r_coil;
  assign o_fb_db      = w_fb_db;
  assign o_closed     = r_closed;
  assign o_busy       = r_busy;
  assign o_fault      = r_fault;
  assign o_fault_code = r_code;

endmodule

// File: tb/tb_contactor_ctrl.sv
// Scoreboard bench for contactor_ctrl: stimulus pushes expected output vectors
// tagged with the cycle they are due; a negedge monitor pops and compares them.
module tb_contactor_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_req_close, i_permit, i_aux_fb, i_fault_clr;
  logic       o_coil, o_fb_db, o_closed, o_busy, o_fault;
  logic [1:0] o_fault_code;

  contactor_ctrl #(
    .DEBOUNCE_CYC  (4),
    .CLOSE_TIMEOUT (20),
    .OPEN_TIMEOUT  (20),
    .CNT_W         (16)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_close  (i_req_close),
    .i_permit     (i_permit),
    .i_aux_fb     (i_aux_fb),
    .i_fault_clr  (i_fault_clr),
    .o_coil       (o_coil),
    .o_fb_db      (o_fb_db),
    .o_closed     (o_closed),
    .o_busy       (o_busy),
    .o_fault      (o_fault),
    .o_fault_code (o_fault_code)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string      tag;
    int         due;
    logic [6:0] vec;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [6:0] obs;
  assign obs = {o_coil, o_fb_db, o_closed, o_busy, o_fault, o_fault_code};

  // Vector layout: {coil, fb_db, closed, busy, fault, code[1:0]}
  function automatic logic [6:0] v(input logic coil, fb, closed, busy, fault,
                                   input logic [1:0] code);
    return {coil, fb, closed, busy, fault, code};
  endfunction

  localparam logic [6:0] V_IDLE    = 7'b0000000;
  localparam logic [6:0] V_CLOSING = 7'b1001000;
  localparam logic [6:0] V_CLOSED  = 7'b1110000;
  localparam logic [6:0] V_OPEN_FB = 7'b0101000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_in(input int d, input string tag, input logic [6:0] vec);
    exp_t e;
    e.tag = tag;
    e.due = cyc + d;
    e.vec = vec;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        chk(sb_q[i].tag, {25'd0, obs}, {25'd0, sb_q[i].vec});
        sb_q.delete(i);
      end
    end
  end

  // From OPEN with aux=0: request, contact answers one cycle later, ends in CLOSED.
  task automatic close_it(input string tag);
    i_req_close = 1'b1;
    i_permit    = 1'b1;
    expect_in(1, {tag, "_closing"}, V_CLOSING);
    tick(1);
    i_aux_fb = 1'b1;
    expect_in(6, {tag, "_fb_up"}, v(1, 1, 0, 1, 0, 2'b00));
    expect_in(7, {tag, "_closed"}, V_CLOSED);
    tick(8);
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_req_close = 1'b0;
    i_permit    = 1'b0;
    i_aux_fb    = 1'b0;
    i_fault_clr = 1'b0;
    tick(2);
    expect_in(0, "reset_state", V_IDLE);
    tick(1);
    i_rst_n = 1'b1;
    tick(1);

    // Normal close then open
    i_req_close = 1'b1;
    i_permit    = 1'b1;
    expect_in(1, "n_coil_on", V_CLOSING);
    tick(3);
    i_aux_fb = 1'b1;
    expect_in(5, "n_fb_latency", V_CLOSING);
    expect_in(6, "n_fb_up", v(1, 1, 0, 1, 0, 2'b00));
    expect_in(7, "n_closed", V_CLOSED);
    tick(8);
    i_req_close = 1'b0;
    expect_in(1, "n_opening", V_OPEN_FB);
    tick(2);
    i_aux_fb = 1'b0;
    expect_in(6, "n_fb_down", v(0, 0, 0, 1, 0, 2'b00));
    expect_in(7, "n_open", V_IDLE);
    tick(8);

    // Close timeout
    i_req_close = 1'b1;
    i_permit    = 1'b1;
    expect_in(20, "to_still_closing", V_CLOSING);
    expect_in(21, "to_fault01", v(0, 0, 0, 0, 1, 2'b01));
    tick(22);
    i_req_close = 1'b0;
    i_fault_clr = 1'b1;
    expect_in(1, "to_cleared", V_IDLE);
    tick(1);
    i_fault_clr = 1'b0;
    tick(1);

    // Debounce glitch, then a real drop-out
    close_it("g");
    i_aux_fb = 1'b0;
    tick(3);
    i_aux_fb = 1'b1;
    expect_in(3, "g_glitch_mid", V_CLOSED);
    expect_in(7, "g_glitch_after", V_CLOSED);
    tick(10);
    i_aux_fb = 1'b0;
    expect_in(6, "g_fb_lost", v(1, 0, 1, 0, 0, 2'b00));
    expect_in(7, "g_fault10", v(0, 0, 0, 0, 1, 2'b10));
    tick(8);
    i_req_close = 1'b0;
    i_fault_clr = 1'b1;
    expect_in(1, "g_cleared", V_IDLE);
    tick(1);
    i_fault_clr = 1'b0;
    tick(1);

    // Permit loss for one cycle
    close_it("p");
    i_permit = 1'b0;
    expect_in(1, "p_opening", V_OPEN_FB);
    tick(1);
    i_permit = 1'b1;
    expect_in(2, "p_no_reclose", V_OPEN_FB);
    tick(2);
    i_aux_fb = 1'b0;
    expect_in(6, "p_fb_down", v(0, 0, 0, 1, 0, 2'b00));
    expect_in(7, "p_open", V_IDLE);
    expect_in(8, "p_reclose", V_CLOSING);
    tick(8);
    i_req_close = 1'b0;
    expect_in(1, "p_abort", v(0, 0, 0, 1, 0, 2'b00));
    expect_in(2, "p_open2", V_IDLE);
    tick(3);

    // Welded contact while opening, fault-clear qualification
    close_it("w");
    i_req_close = 1'b0;
    expect_in(20, "w_still_opening", V_OPEN_FB);
    expect_in(21, "w_fault11", v(0, 1, 0, 0, 1, 2'b11));
    tick(22);
    i_req_close = 1'b1;
    i_fault_clr = 1'b1;
    expect_in(1, "w_clr_req_hi", v(0, 1, 0, 0, 1, 2'b11));
    tick(1);
    i_req_close = 1'b0;
    expect_in(1, "w_clr_fb_hi", v(0, 1, 0, 0, 1, 2'b11));
    tick(1);
    i_fault_clr = 1'b0;
    i_req_close = 1'b1;
    i_aux_fb    = 1'b0;
    expect_in(8, "w_fb_down_held", v(0, 0, 0, 0, 1, 2'b11));
    tick(8);
    i_fault_clr = 1'b1;
    expect_in(1, "w_clr_req_only", v(0, 0, 0, 0, 1, 2'b11));
    tick(1);
    i_req_close = 1'b0;
    expect_in(1, "w_cleared", V_IDLE);
    tick(1);
    i_fault_clr = 1'b0;
    tick(1);

    // Reset while closed, contact still made on release
    close_it("r");
    i_rst_n = 1'b0;
    #1;
    chk("r_async_drop", {25'd0, obs}, {25'd0, V_IDLE});
    expect_in(1, "r_held", V_IDLE);
    tick(2);
    i_rst_n     = 1'b1;
    i_req_close = 1'b0;
    expect_in(6, "r_fb_up_open", v(0, 1, 0, 0, 0, 2'b00));
    expect_in(7, "r_fault11", v(0, 1, 0, 0, 1, 2'b11));
    tick(10);

    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
